// File: rtl/sync_down_counter.sv
// sync_down_counter: 3-bit synchronous down counter with parallel load,
// free-running / one-shot modes, a terminal-count pulse and a RUN/DONE FSM.
// clr is an asynchronous, active-high reset that forces the count to INIT.
module sync_down_counter #(
   parameter logic [2:0] INIT = 3'b111
) (
   input  logic       clk,
   input  logic       clr,
   input  logic       en,
   input  logic       load,
   input  logic [2:0] din,
   input  logic       mode,
   output logic       Qa,
   output logic       Qb,
   output logic       Qc,
   output logic       tc,
   output logic       busy
);

   typedef enum logic {
      RUN  = 1'b0,
      DONE = 1'b1
   } state_t;

   state_t     state_q;
   state_t     state_d;
   logic [2:0] count_q;
   logic [2:0] count_d;
   logic       tc_q;
   logic       tc_d;

   // State, count and terminal-count registers; clr forces the reset image at once.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q <= RUN;
         count_q <= INIT;
         tc_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         tc_q    <= tc_d;
      end
   end

   // Next-state logic: load beats enable beats hold; DONE only leaves via load.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      tc_d    = 1'b0;
      if (load) begin
         // A load never raises tc, even when the loaded value is zero.
         count_d = din;
         if (mode && (din == 3'b000)) begin
            state_d = DONE;
         end else begin
            state_d = RUN;
         end
      end else if (en) begin
         case (state_q)
            RUN: begin
               if (mode && (count_q == 3'b000)) begin
                  // One-shot already sitting at zero (mode changed late): stop, no wrap.
                  state_d = DONE;
                  count_d = count_q;
               end else begin
                  // Decrement wraps 000 -> 111 naturally in free-running mode.
                  count_d = count_q - 3'b001;
                  tc_d    = (count_q == 3'b001);
                  if (mode && (count_q == 3'b001)) begin
                     state_d = DONE;
                  end else begin
                     state_d = RUN;
                  end
               end
            end
            DONE: begin
               state_d = DONE;
               count_d = count_q;
            end
            default: begin
               state_d = RUN;
               count_d = INIT;
            end
         endcase
      end else begin
         state_d = state_q;
         count_d = count_q;
      end
   end

   // Output decode straight from flops, so no input reaches an output combinationally.
   always_comb begin
      Qa   = count_q[0];
      Qb   = count_q[1];
      Qc   = count_q[2];
      tc   = tc_q;
      busy = (state_q == RUN);
   end

endmodule

// File: tb/tb_sync_down_counter.sv
// Self-checking bench for sync_down_counter: directed scenarios followed by
// randomized traffic, all compared against a behavioural model.
module tb_sync_down_counter;

   logic       clk;
   logic       clr;
   logic       en;
   logic       load;
   logic [2:0] din;
   logic       mode;
   logic       Qa;
   logic       Qb;
   logic       Qc;
   logic       tc;
   logic       busy;
   logic [2:0] q_s;

   int checks;
   int failures;

   // Behavioural model: count as plain integer, "finished" flag, last tc.
   int m_count;
   bit m_done;
   bit m_tc;

   sync_down_counter #(.INIT(3'b111)) dut (
      .clk  (clk),
      .clr  (clr),
      .en   (en),
      .load (load),
      .din  (din),
      .mode (mode),
      .Qa   (Qa),
      .Qb   (Qb),
      .Qc   (Qc),
      .tc   (tc),
      .busy (busy)
   );

   assign q_s = {Qc, Qb, Qa};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_count = 7;
      m_done  = 1'b0;
      m_tc    = 1'b0;
   endtask

   // Apply the rules for one rising edge using the inputs currently driven.
   task automatic model_edge();
      if (clr) begin
         model_reset();
      end else if (load) begin
         m_count = int'(din);
         m_tc    = 1'b0;
         m_done  = (mode == 1'b1) && (din == 3'd0);
      end else if (en && !m_done) begin
         if (mode && m_count == 0) begin
            m_done = 1'b1;
            m_tc   = 1'b0;
         end else begin
            m_count = (m_count + 7) % 8;
            m_tc    = (m_count == 0);
            if (mode && m_count == 0) m_done = 1'b1;
         end
      end else begin
         m_tc = 1'b0;
      end
   endtask

   task automatic check_model(input string tag);
      check({tag, "_q"},    {5'd0, q_s},   m_count[7:0]);
      check({tag, "_tc"},   {7'd0, tc},    {7'd0, m_tc});
      check({tag, "_busy"}, {7'd0, busy},  {7'd0, !m_done});
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      check_model(tag);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      clr  = 1'b1;
      en   = 1'b1;
      load = 1'b0;
      din  = 3'd0;
      mode = 1'b0;
      model_reset();

      // Reset state, and the edge at 5 ns is ignored while clr is high.
      #1;
      check("reset_q",    {5'd0, q_s},  8'd7);
      check("reset_tc",   {7'd0, tc},   8'd0);
      check("reset_busy", {7'd0, busy}, 8'd1);
      #6;
      check("clr_hold_q", {5'd0, q_s},  8'd7);
      #3;
      clr = 1'b0;

      // Free-running countdown with wrap: 6,5,4,3,2,1,0,7,6,5.
      for (int i = 0; i < 10; i++) begin
         step("wrap");
         check("wrap_exp_q",  {5'd0, q_s}, 8'((14 - i) % 8));
         check("wrap_exp_tc", {7'd0, tc},  8'(((14 - i) % 8) == 0));
      end

      // Asynchronous clr between edges at Q=101, held across one edge.
      #3;
      clr = 1'b1;
      model_reset();
      #1;
      check("aclr_q",    {5'd0, q_s},  8'd7);
      check("aclr_tc",   {7'd0, tc},   8'd0);
      check("aclr_busy", {7'd0, busy}, 8'd1);
      step("aclr_held");
      clr = 1'b0;
      step("aclr_rel1");
      check("aclr_rel1_exp", {5'd0, q_s}, 8'd6);
      step("aclr_rel2");

      // en low at Q=101 for four cycles, then resume.
      en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step("hold");
         check("hold_exp_q", {5'd0, q_s}, 8'd5);
      end
      en = 1'b1;
      step("resume");
      check("resume_exp_q", {5'd0, q_s}, 8'd4);

      // Load beats enable; one-shot load of zero goes straight to DONE.
      en = 1'b0; load = 1'b1; din = 3'b110;
      step("ld110");
      en = 1'b1; din = 3'b010;
      step("ld_pri");
      check("ld_pri_exp_q", {5'd0, q_s}, 8'd2);
      mode = 1'b1; din = 3'b000;
      step("ld0_oneshot");
      check("ld0_busy", {7'd0, busy}, 8'd0);
      check("ld0_tc",   {7'd0, tc},   8'd0);
      load = 1'b0;

      // In DONE: mode 1->0 with en does not restart; load restarts.
      mode = 1'b0;
      for (int i = 0; i < 3; i++) step("done_mode0");
      check("done_exp_q", {5'd0, q_s}, 8'd0);
      load = 1'b1; din = 3'b100;
      step("done_ld100");
      check("done_ld_busy", {7'd0, busy}, 8'd1);
      load = 1'b0;
      step("done_restart");
      check("done_restart_q", {5'd0, q_s}, 8'd3);

      // One-shot run from 011: 3,2,1,0 then holds with one tc pulse.
      mode = 1'b1; load = 1'b1; en = 1'b0; din = 3'b011;
      step("os_ld");
      load = 1'b0; en = 1'b1;
      for (int i = 0; i < 5; i++) step("oneshot");
      check("os_end_q",    {5'd0, q_s},  8'd0);
      check("os_end_busy", {7'd0, busy}, 8'd0);
      check("os_end_tc",   {7'd0, tc},   8'd0);

      // Free-running reaches zero, then mode flips to one-shot at zero.
      mode = 1'b0; load = 1'b1; din = 3'b001;
      step("fr_ld1");
      load = 1'b0;
      step("fr_to0");
      check("fr_to0_tc", {7'd0, tc}, 8'd1);
      mode = 1'b1;
      step("late_mode");
      check("late_mode_busy", {7'd0, busy}, 8'd0);

      // Load of zero in free-running mode: no tc, stays busy.
      mode = 1'b0; load = 1'b1; din = 3'b000;
      step("ld0_free");
      load = 1'b0;

      // Randomized traffic including occasional mid-cycle clr.
      for (int i = 0; i < 400; i++) begin
         en   = ($urandom_range(0, 3) != 0);
         load = ($urandom_range(0, 7) == 0);
         din  = 3'($urandom_range(0, 7));
         mode = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 39) == 0) begin
            #3;
            clr = 1'b1;
            model_reset();
            #1;
            check_model("rnd_aclr");
         end
         step("rnd");
         clr = 1'b0;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sync_down_counter.md
SYNC_DOWN_COUNTER -- requirements
Module: sync_down_counter

Interface
REQ-001 Parameter INIT, default 3'b111: count value forced by clr.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 clr  input  1  reset, asynchronous, active-high; overrides all other inputs.
REQ-004 en  input  1  count enable; sampled on rising clk.
REQ-005 load  input  1  synchronous parallel load strobe.
REQ-006 din  input  3  parallel load value; din[0] is LSB.
REQ-007 mode  input  1  0 = free-running wrap; 1 = one-shot (stop at 000).
REQ-008 Qa  output  1  count bit 0 (LSB), registered.
REQ-009 Qb  output  1  count bit 1, registered.
REQ-010 Qc  output  1  count bit 2 (MSB), registered.
REQ-011 tc  output  1  terminal-count pulse, registered.
REQ-012 busy  output  1  high while the FSM is in RUN, registered/decoded from state only.

Function
REQ-013 The count {Qc,Qb,Qa} SHALL be a 3-bit unsigned value, modulo 8.
REQ-014 FSM states SHALL be RUN and DONE; busy = 1 in RUN, 0 in DONE.
REQ-015 Edge priority SHALL be: load > en > hold.
REQ-016 load=1: count <= din next edge, regardless of en or state; tc <= 0.
REQ-017 load=1, mode=1, din=000: state <= DONE; otherwise load sets state <= RUN.
REQ-018 load=0, en=1, state RUN: count <= count-1; 000 -> 111 when mode=0.
REQ-019 load=0, en=1, state RUN, mode=1, count=001: count <= 000 and state <= DONE on same edge.
REQ-020 mode=1, state RUN, count=000 (e.g. after mode change): count holds at 000, state <= DONE, no wrap.
REQ-021 tc SHALL be 1 for exactly the one cycle following any edge where count becomes 000 by decrement; 0 otherwise.
REQ-022 tc SHALL never assert on load to 000, on hold, or while in DONE.
REQ-023 en=0 and load=0: count, state hold; tc <= 0.
REQ-024 State DONE: count holds regardless of en or mode; only load or clr leaves DONE.
REQ-025 mode SHALL be sampled every edge; changing mode 1->0 in DONE does not restart counting.
REQ-026 Latency: any load/decrement is visible on Qa..Qc one clk edge after sampling; no combinational input-to-output paths.

Reset
REQ-027 clr=1 SHALL immediately (no clk edge) force count = INIT, state = RUN, tc = 0, busy = 1.
REQ-028 While clr=1, all edges SHALL be ignored; first counting edge is the first rising clk with clr=0.
REQ-029 clr asserted mid-count or in DONE SHALL behave identically to power-on reset.

Verification
REQ-030 clr=1 0-10 ns, then en=1, mode=0, 10 ns clock -> Q = 7,6,5,4,3,2,1,0,7,6...; tc = 1 only in cycle Q=000; busy stays 1.
REQ-031 mode=1, load din=011 then en=1 -> Q = 3,2,1,0 then holds 000; busy falls with Q=000; tc single pulse; further en edges change nothing.
REQ-032 Counting at Q=101, assert clr between clk edges -> Q = 111 immediately, tc = 0, busy = 1; count resumes 6,5... after release.
REQ-033 en dropped at Q=101 for 4 cycles -> Q holds 101, tc = 0; resumes 100 on first en edge.
REQ-034 load=1, en=1, din=010 same edge at Q=110 -> Q = 010 (no decrement); mode=1 load din=000 -> busy = 0, tc = 0.
REQ-035 In DONE, toggle mode 1->0 with en=1 for 3 cycles -> Q stays 000, busy 0; load din=100 -> busy 1, counting restarts.
